pong_match_controller: RTL and testbench

//   Match-level sequencer for the Pong datapath. Holds the ball engine in reset

---
 rtl/pong_match_controller.sv | 181 ++++++++++++++++++
 tb/tb_pong_match_controller.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pong_match_controller.sv
// pong_match_controller
// Match-level sequencer for the Pong datapath. It holds the ball engine in
// reset between rallies and releases it after a serve delay. It detects goals
// from the ball Y position, keeps both scores and declares a winner.
module pong_match_controller #(
   parameter int unsigned HEIGHT      = 320,
   parameter int unsigned WIN_SCORE   = 5,
   parameter int unsigned SERVE_DELAY = 50000000
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       start,
   input  logic [8:0] ballY,
   output logic       ballRst,
   output logic [3:0] score0,
   output logic [3:0] score1,
   output logic       pointPulse,
   output logic [1:0] winner,
   output logic [1:0] gameState
);

   // The display logic decodes this encoding directly, so it must not change.
   typedef enum logic [1:0] {
      S_IDLE  = 2'b00,
      S_SERVE = 2'b01,
      S_PLAY  = 2'b10,
      S_OVER  = 2'b11
   } state_t;

   localparam logic [8:0]  LP_TOP_ROW    = 9'd1;
   localparam logic [8:0]  LP_BOTTOM_ROW = 9'(HEIGHT - 1);
   localparam logic [3:0]  LP_WIN        = 4'(WIN_SCORE);
   localparam logic [31:0] LP_SERVE_LAST = 32'(SERVE_DELAY - 1);

   localparam logic [1:0]  LP_WIN_NONE   = 2'b00;
   localparam logic [1:0]  LP_WIN_P0     = 2'b01;
   localparam logic [1:0]  LP_WIN_P1     = 2'b10;

   state_t      r_state;
   logic [31:0] r_counter;
   logic [3:0]  r_score0;
   logic [3:0]  r_score1;
   logic [1:0]  r_winner;
   logic        r_point_pulse;
   logic        r_ball_rst;
   logic        r_start_prev;

   state_t      w_state_next;
   logic [31:0] w_counter_next;
   logic [3:0]  w_score0_next;
   logic [3:0]  w_score1_next;
   logic [1:0]  w_winner_next;
   logic        w_point_next;
   logic        w_ball_rst_next;

   logic        w_start_edge;
   logic        w_goal_top;
   logic        w_goal_bottom;
   logic [3:0]  w_score0_inc;
   logic [3:0]  w_score1_inc;

   // A start that is still held when reset is released has startPrev = 1, so it
   // does not register as a press.
   assign w_start_edge  = start & ~r_start_prev;
   // The top wall is checked first. Player 0 missed the ball there.
   assign w_goal_top    = (ballY == LP_TOP_ROW);
   assign w_goal_bottom = (ballY == LP_BOTTOM_ROW);
   // A score never goes above LP_WIN, so these 4-bit increments never wrap.
   assign w_score0_inc  = r_score0 + 4'd1;
   assign w_score1_inc  = r_score1 + 4'd1;

   // State register and registered outputs. Synchronous reset has priority over every other event.
   // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
   always_ff @(posedge clock) begin
      if (reset) begin
         r_state       <= S_IDLE;
         r_counter     <= '0;
         r_score0      <= '0;
         r_score1      <= '0;
         r_winner      <= LP_WIN_NONE;
         r_point_pulse <= 1'b0;
         r_ball_rst    <= 1'b1;
         r_start_prev  <= 1'b1;
      end else begin
         r_state       <= w_state_next;
         r_counter     <= w_counter_next;
         r_score0      <= w_score0_next;
         r_score1      <= w_score1_next;
         r_winner      <= w_winner_next;
         r_point_pulse <= w_point_next;
         r_ball_rst    <= w_ball_rst_next;
         r_start_prev  <= start;
      end
   end

   // Next-state and serve-delay counter logic.
   // NOTE: each combinational output gets a default first, so no path can infer a latch.
   always_comb begin
      w_state_next   = r_state;
      w_counter_next = r_counter;
      case (r_state)
         S_IDLE: begin
            if (w_start_edge) begin
               w_state_next   = S_SERVE;
               w_counter_next = '0;
            end
         end
         S_SERVE: begin
            if (r_counter == LP_SERVE_LAST) begin
               w_state_next   = S_PLAY;
               w_counter_next = '0;
            end else begin
               w_counter_next = r_counter + 32'd1;
            end
         end
         S_PLAY: begin
            if (w_goal_top) begin
               w_state_next   = (w_score1_inc == LP_WIN) ? S_OVER : S_SERVE;
               w_counter_next = '0;
            end else if (w_goal_bottom) begin
               w_state_next   = (w_score0_inc == LP_WIN) ? S_OVER : S_SERVE;
               w_counter_next = '0;
            end
         end
         S_OVER: begin
            if (w_start_edge) begin
               w_state_next   = S_SERVE;
               w_counter_next = '0;
            end
         end
         default: begin
            w_state_next   = S_IDLE;
            w_counter_next = '0;
         end
      endcase
   end

   // Next values of scores, winner, point strobe and ball reset.
   always_comb begin
      w_score0_next   = r_score0;
      w_score1_next   = r_score1;
      w_winner_next   = r_winner;
      w_point_next    = 1'b0;
      // The ball is released only while in PLAY, so ballRst changes on the same edge as gameState.
      w_ball_rst_next = (w_state_next != S_PLAY);
      case (r_state)
         S_IDLE, S_OVER: begin
            if (w_start_edge) begin
               w_score0_next = '0;
               w_score1_next = '0;
               w_winner_next = LP_WIN_NONE;
            end
         end
         S_PLAY: begin
            if (w_goal_top) begin
               w_score1_next = w_score1_inc;
               w_point_next  = 1'b1;
               if (w_score1_inc == LP_WIN) begin
                  w_winner_next = LP_WIN_P1;
               end
            end else if (w_goal_bottom) begin
               w_score0_next = w_score0_inc;
               w_point_next  = 1'b1;
               if (w_score0_inc == LP_WIN) begin
                  w_winner_next = LP_WIN_P0;
               end
            end
         end
         default: begin
         end
      endcase
   end

   assign gameState  = r_state;
   assign ballRst    = r_ball_rst;
   assign score0     = r_score0;
   assign score1     = r_score1;
   assign winner     = r_winner;
   assign pointPulse = r_point_pulse;

endmodule

// File: tb/tb_pong_match_controller.sv
// tb_pong_match_controller
// Scoreboard bench for pong_match_controller. The stimulus pushes the expected
// output snapshot for a cycle into a queue. A monitor pops each snapshot on the
// falling edge of that cycle and compares it. Every point strobe is matched
// against a second queue of expected scores.
module tb_pong_match_controller;

   localparam int unsigned HEIGHT      = 320;
   localparam int unsigned WIN_SCORE   = 5;
   localparam int unsigned SERVE_DELAY = 16;

   localparam logic [1:0] ST_IDLE  = 2'b00;
   localparam logic [1:0] ST_SERVE = 2'b01;
   localparam logic [1:0] ST_PLAY  = 2'b10;
   localparam logic [1:0] ST_OVER  = 2'b11;

   logic       clock;
   logic       reset;
   logic       start;
   logic [8:0] ballY;
   logic       ballRst;
   logic [3:0] score0;
   logic [3:0] score1;
   logic       pointPulse;
   logic [1:0] winner;
   logic [1:0] gameState;

   typedef struct {
      int         cyc;
      string      name;
      logic [1:0] st;
      logic       brst;
      logic [3:0] s0;
      logic [3:0] s1;
      logic       pulse;
      logic [1:0] win;
   } snap_t;

   snap_t      snap_q[$];
   logic [7:0] pulse_q[$];

   int cyc     = 0;
   int n_checks = 0;
   int n_fail   = 0;

   pong_match_controller #(
      .HEIGHT     (HEIGHT),
      .WIN_SCORE  (WIN_SCORE),
      .SERVE_DELAY(SERVE_DELAY)
   ) dut (
      .clock     (clock),
      .reset     (reset),
      .start     (start),
      .ballY     (ballY),
      .ballRst   (ballRst),
      .score0    (score0),
      .score1    (score1),
      .pointPulse(pointPulse),
      .winner    (winner),
      .gameState (gameState)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   initial begin
      forever begin
         @(posedge clock);
         cyc++;
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
      end
   endtask

   // Monitor: compares snapshots that fall due and matches every point strobe.
   initial begin
      forever begin
         @(negedge clock);
         while (snap_q.size() > 0 && snap_q[0].cyc <= cyc) begin
            snap_t s;
            s = snap_q.pop_front();
            if (s.cyc < cyc) begin
               check({s.name, "_stale"}, 16'(cyc), 16'(s.cyc));
            end else begin
               check(s.name,
                     {3'b0, gameState, ballRst, score0, score1, pointPulse, winner},
                     {3'b0, s.st, s.brst, s.s0, s.s1, s.pulse, s.win});
            end
         end
         if (pointPulse === 1'b1) begin
            if (pulse_q.size() == 0) begin
               check("unexpected_point_pulse", {8'h0, score0, score1}, 16'hFFFF);
            end else begin
               logic [7:0] e;
               e = pulse_q.pop_front();
               check("point_pulse_scores", {8'h0, score0, score1}, {8'h0, e});
            end
         end
      end
   end

   // One clock cycle. Inputs are driven 1 time unit after the rising edge.
   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic expect_now(input string name, input logic [1:0] st, input logic brst,
                             input logic [3:0] s0, input logic [3:0] s1,
                             input logic pulse, input logic [1:0] win);
      snap_t s;
      s.cyc = cyc; s.name = name; s.st = st; s.brst = brst;
      s.s0 = s0; s.s1 = s1; s.pulse = pulse; s.win = win;
      snap_q.push_back(s);
   endtask

   // Ensures start is low for a cycle, then raises it for one cycle.
   task automatic press_start();
      start = 1'b0;
      tick();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   // Called right after the edge that entered SERVE. Checks 16 SERVE cycles and then
   // the entry into PLAY. During SERVE it drives a goal row and a start edge, which must both be ignored.
   task automatic serve_wait(input logic [3:0] s0, input logic [3:0] s1, input logic first_pulse);
      for (int i = 0; i < 16; i++) begin
         expect_now("serve", ST_SERVE, 1'b1, s0, s1, (i == 0) ? first_pulse : 1'b0, 2'b00);
         if (i == 0)  ballY = 9'd1;
         if (i == 2)  start = 1'b1;
         if (i == 3)  start = 1'b0;
         if (i == 15) ballY = 9'd160;
         tick();
      end
      expect_now("play_entry", ST_PLAY, 1'b0, s0, s1, 1'b0, 2'b00);
   endtask

   // Drives a goal row for one cycle from PLAY. win != 0 means this goal ends the match.
   task automatic goal(input logic [8:0] y, input logic [3:0] s0, input logic [3:0] s1,
                       input logic [1:0] win);
      ballY = y;
      tick();
      ballY = 9'd160;
      pulse_q.push_back({s0, s1});
      if (win != 2'b00) begin
         expect_now("goal_over", ST_OVER, 1'b1, s0, s1, 1'b1, win);
      end else begin
         serve_wait(s0, s1, 1'b1);
      end
   endtask

   initial begin
      reset = 1'b1;
      start = 1'b0;
      ballY = 9'd160;

      // 1. reset state, first serve and release
      tick();
      expect_now("reset_state", ST_IDLE, 1'b1, 4'd0, 4'd0, 1'b0, 2'b00);
      reset = 1'b0;
      tick();
      expect_now("idle_hold", ST_IDLE, 1'b1, 4'd0, 4'd0, 1'b0, 2'b00);
      press_start();
      serve_wait(4'd0, 4'd0, 1'b0);

      // 2. top-wall goal, player 1 scores
      goal(9'd1, 4'd0, 4'd1, 2'b00);

      // 3. non-goal rows and a start edge in PLAY, then a bottom-wall goal
      ballY = 9'd5;
      tick();
      expect_now("no_goal_y5", ST_PLAY, 1'b0, 4'd0, 4'd1, 1'b0, 2'b00);
      ballY = 9'd160;
      tick();
      expect_now("no_goal_y160", ST_PLAY, 1'b0, 4'd0, 4'd1, 1'b0, 2'b00);
      start = 1'b1;
      tick();
      expect_now("start_in_play", ST_PLAY, 1'b0, 4'd0, 4'd1, 1'b0, 2'b00);
      start = 1'b0;
      goal(9'd319, 4'd1, 4'd1, 2'b00);

      // 4. player 0 reaches five points, then OVER holds and restarts
      goal(9'd319, 4'd2, 4'd1, 2'b00);
      goal(9'd319, 4'd3, 4'd1, 2'b00);
      goal(9'd319, 4'd4, 4'd1, 2'b00);
      goal(9'd319, 4'd5, 4'd1, 2'b01);
      ballY = 9'd1;
      tick();
      expect_now("over_ignores_ball", ST_OVER, 1'b1, 4'd5, 4'd1, 1'b0, 2'b01);
      tick();
      expect_now("over_hold", ST_OVER, 1'b1, 4'd5, 4'd1, 1'b0, 2'b01);
      ballY = 9'd160;
      press_start();
      serve_wait(4'd0, 4'd0, 1'b0);

      // 6a. reset in PLAY with score1 = 3
      goal(9'd1, 4'd0, 4'd1, 2'b00);
      goal(9'd1, 4'd0, 4'd2, 2'b00);
      goal(9'd1, 4'd0, 4'd3, 2'b00);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      expect_now("reset_in_play", ST_IDLE, 1'b1, 4'd0, 4'd0, 1'b0, 2'b00);

      // 6b. reset at SERVE cycle 8
      press_start();
      for (int i = 0; i < 8; i++) begin
         expect_now("serve_pre_reset", ST_SERVE, 1'b1, 4'd0, 4'd0, 1'b0, 2'b00);
         tick();
      end
      reset = 1'b1;
      tick();
      reset = 1'b0;
      expect_now("reset_in_serve", ST_IDLE, 1'b1, 4'd0, 4'd0, 1'b0, 2'b00);

      // 5. start held through reset does not trigger; a fresh press triggers once
      start = 1'b1;
      reset = 1'b1;
      tick();
      reset = 1'b0;
      tick();
      expect_now("held_start_1", ST_IDLE, 1'b1, 4'd0, 4'd0, 1'b0, 2'b00);
      tick();
      expect_now("held_start_2", ST_IDLE, 1'b1, 4'd0, 4'd0, 1'b0, 2'b00);
      start = 1'b0;
      tick();
      expect_now("released_start", ST_IDLE, 1'b1, 4'd0, 4'd0, 1'b0, 2'b00);
      start = 1'b1;
      tick();
      serve_wait(4'd0, 4'd0, 1'b0);

      // player 1 wins through the top wall
      goal(9'd1, 4'd0, 4'd1, 2'b00);
      goal(9'd1, 4'd0, 4'd2, 2'b00);
      goal(9'd1, 4'd0, 4'd3, 2'b00);
      goal(9'd1, 4'd0, 4'd4, 2'b00);
      goal(9'd1, 4'd0, 4'd5, 2'b10);
      tick();
      expect_now("p1_over_hold", ST_OVER, 1'b1, 4'd0, 4'd5, 1'b0, 2'b10);

      tick();
      tick();
      check("snapshots_drained", 16'(snap_q.size()), 16'd0);
      check("pulses_drained", 16'(pulse_q.size()), 16'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
